// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch controller driving the UART transmitter's DATA_VALID/Busy handshake.
// Defining UART_FEEDER_OVERFLOW_EN adds a sticky OVERFLOW flag with CLR_OVF clear.
module uart_tx_feeder #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      WR_DATA,
    input  logic                  WR_EN,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic [WIDTH-1:0]      P_DATA,
    output logic                  DATA_VALID,
    input  logic                  Busy
`ifdef UART_FEEDER_OVERFLOW_EN
    ,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVF
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [WIDTH-1:0]      pdata_q, pdata_d;
    logic                  full_q, empty_q, dv_q;
    logic                  wr_accept, pop;

    // A write seen while full is lost even if a pop happens on the same edge.
    assign wr_accept = WR_EN && !full_q;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q && !Busy) begin
                    state_d = S_LAUNCH;
                    pop     = 1'b1;
                end
            end
            S_LAUNCH:    state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (Busy)  state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!Busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pdata_d  = pdata_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            pdata_d  = mem_q[rd_ptr_q];
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_accept) mem_q[wr_ptr_q] <= WR_DATA;
    end

    // Flags and the launch pulse are registered from next-state values so they line up with COUNT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pdata_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pdata_q  <= pdata_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
            dv_q     <= (state_d == S_LAUNCH);
        end
    end

    assign FULL       = full_q;
    assign EMPTY      = empty_q;
    assign COUNT      = count_q;
    assign P_DATA     = pdata_q;
    assign DATA_VALID = dv_q;

`ifdef UART_FEEDER_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else if (WR_EN && full_q) begin
            ovf_q <= 1'b1;
        end else if (CLR_OVF) begin
            ovf_q <= 1'b0;
        end
    end

    assign OVERFLOW = ovf_q;
`endif

endmodule
